nco_ctrl: RTL

NCO_CTRL -- requirements
Module: nco_ctrl

---
 rtl/nco_pkg.sv | 20 ++
 rtl/nco_fstep_reg.sv | 61 ++++++
 rtl/nco_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/nco_pkg.sv
// Shared defaults, state encoding and helpers for the NCO table-load / run controller.
package nco_pkg;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned FSTEP_W_DEF = 14;
  localparam int unsigned LUT_DEPTH   = 1 << ADDR_W_DEF;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_LOAD = 2'd1;
  localparam state_t S_RUN  = 2'd2;
  localparam state_t S_STOP = 2'd3;

  function automatic logic is_active(input state_t s);
    return (s == S_RUN) || (s == S_STOP);
  endfunction

endpackage

// File: rtl/nco_fstep_reg.sv
// Frequency-step pending/apply register. With NCO_CTRL_SYNC_UPD_EN defined, steps captured
// while the NCO is active are held until the next phase wrap; otherwise they apply immediately.
module nco_fstep_reg
  import nco_pkg::*;
#(
  parameter int unsigned FSTEP_W = FSTEP_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               active_i,
  input  logic [FSTEP_W-1:0] freq_step_i,
  input  logic               freq_upd_i,
  input  logic               phase_wrap_i,
  output logic [FSTEP_W-1:0] freq_step_o
);

  logic [FSTEP_W-1:0] step_q, step_d;
  logic [FSTEP_W-1:0] pend_q, pend_d;
  logic               pvld_q, pvld_d;

`ifndef NCO_CTRL_SYNC_UPD_EN
  logic unused_sync;
  assign unused_sync = ^{active_i, phase_wrap_i, pvld_q};
`endif

  always_comb begin
    pend_d = freq_upd_i ? freq_step_i : pend_q;
    step_d = step_q;
    pvld_d = pvld_q;
`ifdef NCO_CTRL_SYNC_UPD_EN
    if (!active_i) begin
      if (freq_upd_i) step_d = freq_step_i;
      pvld_d = 1'b0;
    end else if (phase_wrap_i) begin
      // a strobe coincident with the wrap takes effect at that same wrap
      if (freq_upd_i || pvld_q) step_d = pend_d;
      pvld_d = 1'b0;
    end else if (freq_upd_i) begin
      pvld_d = 1'b1;
    end
`else
    if (freq_upd_i) step_d = freq_step_i;
    pvld_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      step_q <= '0;
      pend_q <= '0;
      pvld_q <= 1'b0;
    end else begin
      step_q <= step_d;
      pend_q <= pend_d;
      pvld_q <= pvld_d;
    end
  end

  assign freq_step_o = step_q;

endmodule

// File: rtl/nco_ctrl.sv
// NCO controller: streams a sample table into the NCO LUT, gates accumulation, tracks errors.
// Optional macro NCO_CTRL_SYNC_UPD_EN defers active-state step updates to phase wraps.
module nco_ctrl
  import nco_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned FSTEP_W = FSTEP_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en_i,
  input  logic               load_req_i,
  input  logic               s_valid_i,
  input  logic [DATA_W-1:0]  s_data_i,
  output logic               s_ready_o,
  input  logic [FSTEP_W-1:0] freq_step_i,
  input  logic               freq_upd_i,
  input  logic               phase_wrap_i,
  output logic               nco_we_o,
  output logic [ADDR_W-1:0]  nco_addr_o,
  output logic [DATA_W-1:0]  nco_data_o,
  output logic [FSTEP_W-1:0] nco_freq_step_o,
  output logic               nco_run_o,
  output logic               load_done_o,
  output logic               err_o
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic               tv_q, tv_d;
  logic               err_q, err_d;
  logic               ready_q;
  logic               we_q, done_q, run_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               beat;
  logic               active;

  assign beat   = (state_q == S_LOAD) && s_valid_i && ready_q;
  assign active = is_active(state_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tv_d    = tv_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (load_req_i) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          tv_d    = 1'b0;
          err_d   = 1'b0;
        end else if (en_i) begin
          if (tv_q) state_d = S_RUN;
          else      err_d   = 1'b1;
        end
      end
      S_LOAD: begin
        if (beat) begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (&cnt_q) begin
            state_d = S_IDLE;
            tv_d    = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (load_req_i) err_d = 1'b1;
        if (!en_i) state_d = S_STOP;
      end
      S_STOP: begin
        if (load_req_i) err_d = 1'b1;
        if (phase_wrap_i)  state_d = S_IDLE;
        else if (en_i)     state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tv_q    <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tv_q    <= tv_d;
      err_q   <= err_d;
      ready_q <= (state_d == S_LOAD);
      we_q    <= beat;
      addr_q  <= beat ? cnt_q : '0;
      data_q  <= beat ? s_data_i : '0;
      done_q  <= beat && (&cnt_q);
      run_q   <= active;
    end
  end

  nco_fstep_reg #(
    .FSTEP_W (FSTEP_W)
  ) u_fstep (
    .clk          (clk),
    .reset_n      (reset_n),
    .active_i     (active),
    .freq_step_i  (freq_step_i),
    .freq_upd_i   (freq_upd_i),
    .phase_wrap_i (phase_wrap_i),
    .freq_step_o  (nco_freq_step_o)
  );

  assign s_ready_o   = ready_q;
  assign nco_we_o    = we_q;
  assign nco_addr_o  = addr_q;
  assign nco_data_o  = data_q;
  assign nco_run_o   = run_q;
  assign load_done_o = done_q;
  assign err_o       = err_q;

endmodule
